// File: rtl/mining_pkg.sv
// Shared types and constants for the nonce result scanner.
// SCAN_WRITEBACK_EN adds the WB0/WB1 states to the scanner FSM.
package mining_pkg;

  localparam int          DEFAULT_NUM_NONCES = 16;
  localparam logic [31:0] HASH_RESET         = 32'hFFFF_FFFF;
  localparam int          WB_STATUS_OFS      = 0;
  localparam int          WB_HASH_OFS        = 1;

`ifdef SCAN_WRITEBACK_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_SCAN, ST_FLUSH, ST_WB0, ST_WB1, ST_DONE
  } scan_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_SCAN, ST_FLUSH, ST_DONE
  } scan_state_e;
`endif

endpackage

// File: rtl/scan_min_tracker.sv
// Running hit counter and minimum tracker over a stream of (index, word) pairs.
// clear re-arms the unit for a new scan; valid consumes one word.
module scan_min_tracker
  import mining_pkg::*;
#(
  parameter  int NUM_NONCES = DEFAULT_NUM_NONCES,
  localparam int NW         = $clog2(NUM_NONCES),
  localparam int CW         = $clog2(NUM_NONCES + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   word,
  input  logic [NW-1:0] index,
  input  logic          valid,
  input  logic          clear,
  input  logic [31:0]   target,
  output logic          found,
  output logic [CW-1:0] hit_count,
  output logic [NW-1:0] best_nonce,
  output logic [31:0]   best_hash
);

  logic          found_q, found_d;
  logic [CW-1:0] hit_count_q, hit_count_d;
  logic [NW-1:0] best_nonce_q, best_nonce_d;
  logic [31:0]   best_hash_q, best_hash_d;
  logic          hit, better;

  assign hit    = word < target;
  // strict compare: on a tie the earlier (lower) nonce is kept
  assign better = word < best_hash_q;

  always_comb begin
    found_d      = found_q;
    hit_count_d  = hit_count_q;
    best_nonce_d = best_nonce_q;
    best_hash_d  = best_hash_q;
    if (clear) begin
      found_d      = 1'b0;
      hit_count_d  = '0;
      best_nonce_d = '0;
      best_hash_d  = HASH_RESET;
    end else if (valid) begin
      found_d     = found_q | hit;
      hit_count_d = hit_count_q + CW'(hit);
      if (better) begin
        best_nonce_d = index;
        best_hash_d  = word;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found_q      <= 1'b0;
      hit_count_q  <= '0;
      best_nonce_q <= '0;
      best_hash_q  <= HASH_RESET;
    end else begin
      found_q      <= found_d;
      hit_count_q  <= hit_count_d;
      best_nonce_q <= best_nonce_d;
      best_hash_q  <= best_hash_d;
    end
  end

  assign found      = found_q;
  assign hit_count  = hit_count_q;
  assign best_nonce = best_nonce_q;
  assign best_hash  = best_hash_q;

endmodule

// File: rtl/nonce_result_scanner.sv
// Reads NUM_NONCES result words back from SRAM (one per cycle) and reports hits and the minimum.
// SCAN_WRITEBACK_EN: after the scan, write a status word and the best hash just past the region.
module nonce_result_scanner
  import mining_pkg::*;
#(
  parameter  int NUM_NONCES = DEFAULT_NUM_NONCES,
  parameter  int ADDR_W     = 16,
  localparam int NW         = $clog2(NUM_NONCES),
  localparam int CW         = $clog2(NUM_NONCES + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] result_addr,
  input  logic [31:0]       target,
  output logic              done,
  output logic              found,
  output logic [CW-1:0]     hit_count,
  output logic [NW-1:0]     best_nonce,
  output logic [31:0]       best_hash,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  localparam int RW = NW + 1;

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       target_q, target_d;
  logic [RW-1:0]     rd_idx_q, rd_idx_d;
  logic [NW-1:0]     cons_idx_q, cons_idx_d;
  logic [1:0]        vld_pipe_q, vld_pipe_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              issue, trk_clear, last_issued;

  assign mem_clk     = clk;
  assign last_issued = rd_idx_q == RW'(NUM_NONCES);

  // ---- state register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // ---- next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SCAN;
      ST_SCAN:  if (last_issued) state_d = ST_FLUSH;
`ifdef SCAN_WRITEBACK_EN
      ST_FLUSH: state_d = ST_WB0;
      ST_WB0:   state_d = ST_WB1;
      ST_WB1:   state_d = ST_DONE;
`else
      ST_FLUSH: state_d = ST_DONE;
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

`ifdef SCAN_WRITEBACK_EN
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
`endif

  // ---- outputs / datapath ----
  // vld_pipe[0]: address issued last edge; vld_pipe[1]: its read data is on mem_read_data now.
  always_comb begin
    base_d     = base_q;
    target_d   = target_q;
    rd_idx_d   = rd_idx_q;
    cons_idx_d = cons_idx_q;
    done_d     = done_q;
    mem_addr_d = mem_addr_q;
    issue      = 1'b0;
    trk_clear  = 1'b0;
`ifdef SCAN_WRITEBACK_EN
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
`endif
    case (state_q)
      ST_IDLE: if (start) begin
        base_d     = result_addr;
        target_d   = target;
        done_d     = 1'b0;
        mem_addr_d = result_addr;
        rd_idx_d   = RW'(1);
        cons_idx_d = '0;
        issue      = 1'b1;
        trk_clear  = 1'b1;
      end
      ST_SCAN: if (!last_issued) begin
        mem_addr_d = base_q + ADDR_W'(rd_idx_q);
        rd_idx_d   = rd_idx_q + RW'(1);
        issue      = 1'b1;
      end
`ifdef SCAN_WRITEBACK_EN
      // tracker holds final results by now; the write is presented for one cycle each
      ST_WB0: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = base_q + ADDR_W'(NUM_NONCES + WB_STATUS_OFS);
        mem_wdata_d = {found, 15'(hit_count), 16'(best_nonce)};
      end
      ST_WB1: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = base_q + ADDR_W'(NUM_NONCES + WB_HASH_OFS);
        mem_wdata_d = best_hash;
      end
`endif
      ST_DONE: begin
        done_d = 1'b1;
`ifdef SCAN_WRITEBACK_EN
        mem_we_d = 1'b0;
`endif
      end
      default: ;
    endcase
    if (vld_pipe_q[1]) cons_idx_d = cons_idx_q + NW'(1);
    vld_pipe_d = {vld_pipe_q[0], issue};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      target_q   <= '0;
      rd_idx_q   <= '0;
      cons_idx_q <= '0;
      vld_pipe_q <= '0;
      done_q     <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      base_q     <= base_d;
      target_q   <= target_d;
      rd_idx_q   <= rd_idx_d;
      cons_idx_q <= cons_idx_d;
      vld_pipe_q <= vld_pipe_d;
      done_q     <= done_d;
      mem_addr_q <= mem_addr_d;
    end
  end

`ifdef SCAN_WRITEBACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  assign mem_we         = mem_we_q;
  assign mem_write_data = mem_wdata_q;
`else
  assign mem_we         = 1'b0;
  assign mem_write_data = '0;
`endif

  assign done     = done_q;
  assign mem_addr = mem_addr_q;

  scan_min_tracker #(.NUM_NONCES(NUM_NONCES)) u_trk (
    .clk       (clk),
    .reset_n   (reset_n),
    .word      (mem_read_data),
    .index     (cons_idx_q),
    .valid     (vld_pipe_q[1]),
    .clear     (trk_clear),
    .target    (target_q),
    .found     (found),
    .hit_count (hit_count),
    .best_nonce(best_nonce),
    .best_hash (best_hash)
  );

endmodule

// File: doc/nonce_result_scanner.md
Name: nonce_result_scanner

Overview:
- Reader for the hash engine's output region: after the miner writes one H0 word per nonce at output_addr+nonce, this block reads the NUM_NONCES words back over the same single-port SRAM interface.
- Compares each word unsigned against a difficulty target; reports whether any nonce hit, the hit count, and the minimum-hash nonce.
- Sits beside the miner on the shared memory bus; the top-level controller starts it after the miner's done rises.

Parameters:
- NUM_NONCES, 16, number of result words scanned (≥2); nonce index width NW = $clog2(NUM_NONCES), count width CW = $clog2(NUM_NONCES+1).
- ADDR_W, 16, memory address width.

Ports:
- clk  in  1  clock; also forwarded as mem_clk.
- reset_n  in  1  async active-low reset.
- start  in  1  begin scan; sampled only in IDLE.
- result_addr  in  ADDR_W  base address of the result words.
- target  in  32  difficulty threshold; hit when word < target (unsigned).
- done  out  1  scan complete; held until the next accepted start.
- found  out  1  at least one hit.
- hit_count  out  CW  number of hits.
- best_nonce  out  NW  index of the minimum word.
- best_hash  out  32  minimum word value.
- mem_clk  out  1  = clk.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_write_data  out  32  write data.
- mem_read_data  in  32  SRAM read data, valid the cycle after the address is presented.

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk.
- Reset values: done=0, found=0, hit_count=0, best_nonce=0, best_hash=32'hFFFFFFFF, mem_we=0, mem_addr=0, mem_write_data=0; state=IDLE.
- States: IDLE, SCAN, FLUSH, (WB0, WB1 with the optional feature), DONE.
- IDLE, start=1:
  - latch result_addr and target;
  - clear done/found/hit_count;
  - set best_hash=FFFFFFFF and best_nonce=0;
  - mem_addr<=result_addr, rd_idx<=1, go SCAN.
- SCAN, pipelined (one word per cycle):
  - each cycle consumes mem_read_data for index rd_idx-1 and issues mem_addr<=base+rd_idx;
  - when rd_idx==NUM_NONCES, issue nothing new and go FLUSH.
- FLUSH: consume the last word (index NUM_NONCES-1), then go DONE (or WB0).
- Consume rules:
  - hit = word < latched target; hit_count += hit; found |= hit.
  - If word < best_hash, update best_hash/best_nonce.
  - Strict < means ties keep the lower nonce.
  - word==target is not a hit.
- DONE: done<=1, return to IDLE. Outputs hold until the next start.
- Latency: start accepted at cycle 0 → done high at cycle NUM_NONCES+2 (no write-back).
- start while not in IDLE is ignored. target/result_addr changes after acceptance have no effect.
- Address arithmetic is modulo 2^ADDR_W; wrap past FFFF is legal.
- All words FFFFFFFF: best_nonce=0, best_hash=FFFFFFFF, found=0 unless target > FFFFFFFF (impossible), so found=0.
- reset_n low mid-scan: immediate return to reset values. No memory write is in flight.
- mem_we=0 at all times without the optional feature.

Optional Feature:
- Macro SCAN_WRITEBACK_EN.
- When defined: after FLUSH, go WB0 then WB1, in which mem_we=1:
  - WB0: mem_addr=base+NUM_NONCES, mem_write_data={found, hit_count zero-extended to 15 bits, 16'(best_nonce)};
  - WB1: mem_addr=base+NUM_NONCES+1, mem_write_data=best_hash;
  - then DONE with mem_we<=0. Latency becomes NUM_NONCES+4.
- When undefined: WB states are absent, mem_we and mem_write_data are constant 0.

Decomposition:
- Package mining_pkg: state enum type, DEFAULT_NUM_NONCES=16, HASH_RESET=32'hFFFFFFFF, writeback offsets (WB_STATUS_OFS=0, WB_HASH_OFS=1 relative to base+NUM_NONCES).
- One natural sub-module: scan_min_tracker, the combinational-plus-register compare/min/count unit (inputs: word, index, valid, clear, target; outputs: found, hit_count, best_nonce, best_hash). The FSM and address generation stay in the top.

Test Plan:
- Memory words at 0x0100..0x010F = 0x10000000+i, target=0x10000003, start → done at cycle 18, found=1, hit_count=3, best_nonce=0, best_hash=0x10000000.
- Words all 0x80000000 except index 9 = 0x00000005, target=0x00000001 → found=0, hit_count=0, best_nonce=9, best_hash=0x00000005.
- Indices 4 and 11 both = 0x00000002, others larger → best_nonce=4 (tie keeps lower). Word equal to target is not counted.
- result_addr=0xFFF8 → addresses 0xFFF8..0xFFFF then 0x0000..0x0007 read in order; results correct. Second start pulse mid-scan is ignored.
- reset_n asserted at cycle 7 of a scan → all outputs at reset values next edge; a fresh start completes normally.
- With SCAN_WRITEBACK_EN, first scenario → writes 0x80030000 to 0x0110 and 0x10000000 to 0x0111; done at cycle 20.
